// File: rtl/div.sv
// Fixed-point scaling stage for the LMS weight update: divides a signed product
// by 2^SHIFT with round-half-up, saturates to OUT_W bits, two register stages.
module div #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 14,
  parameter int SHIFT = 13
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  // Rounding constant and clamp limits, all one bit wider than the input so the
  // rounding add can never overflow.
  localparam logic signed [IN_W:0] RND   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [IN_W-1:0]  s1_q, s1_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic signed [IN_W:0] t_w;
  logic signed [IN_W:0] q_w;

  always_comb begin
    s1_d  = in;
    t_w   = {s1_q[IN_W-1], s1_q} + RND;
    q_w   = t_w >>> SHIFT;
    out_d = q_w[OUT_W-1:0];
    if (q_w > MAX_V) begin
      out_d = MAX_V[OUT_W-1:0];
    end else if (q_w < MIN_V) begin
      out_d = MIN_V[OUT_W-1:0];
    end
  end

  // Despite its name, rstn is an active-high asynchronous clear.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_q  <= '0;
      out_q <= '0;
    end else begin
      s1_q  <= s1_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_div.sv
// Randomized and directed bench for div: reference model from plain real
// arithmetic on a history of sampled inputs, checked every negative clock edge.
module tb_div;
  localparam int IN_W  = 28;
  localparam int OUT_W = 14;
  localparam int SHIFT = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  in_v;
  logic [OUT_W-1:0] out_v;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [IN_W-1:0] hist[$];
  int              lit_due[$];
  longint          lit_exp[$];

  always #5 clk = ~clk;

  div #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rstn(rst),
    .in  (in_v),
    .out (out_v)
  );

  function automatic longint ref_fn(input logic [IN_W-1:0] x);
    longint sx;
    longint q;
    longint hi;
    longint lo;
    real    r;
    sx = longint'($signed(x));
    r  = $floor(real'(sx) / (2.0 ** SHIFT) + 0.5);
    q  = longint'(r);
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // History of inputs sampled since the last reset; output reflects the older one.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
    end else begin
      hist.push_back(in_v);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    longint exp_v;
    exp_v = 0;
    if (!rst && hist.size() == 2) exp_v = ref_fn(hist[0]);
    check("stream", longint'($signed(out_v)), exp_v);
    if (lit_due.size() > 0 && lit_due[0] == cyc) begin
      check("literal", longint'($signed(out_v)), lit_exp[0]);
      void'(lit_due.pop_front());
      void'(lit_exp.pop_front());
    end
  end

  task automatic push_lit(input int due, input longint e);
    lit_due.push_back(due);
    lit_exp.push_back(e);
  endtask

  task automatic drive(input int v);
    @(posedge clk);
    #1 in_v = IN_W'(v);
  endtask

  task automatic drive_lit(input int v, input longint e);
    drive(v);
    push_lit(cyc + 2, e);
  endtask

  initial begin
    int s;
    rst  = 1'b1;
    in_v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Exact and rounding, positive, back to back
    drive_lit(8192, 1);
    drive_lit(4096, 1);
    drive_lit(4095, 0);
    drive_lit(12288, 2);
    // Rounding, negative
    drive_lit(-4096, 0);
    drive_lit(-4097, -1);
    drive_lit(-8192, -1);
    drive_lit(-12289, -2);
    // Saturation
    drive_lit(67100672, 8191);
    drive_lit(67108864, 8191);
    drive_lit(-67108864, -8192);
    drive_lit(-134217728, -8192);
    drive_lit(134217727, 8191);
    drive_lit(0, 0);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-cycle, then release holding 65536
    drive(65536);
    #2 rst = 1'b1;
    #1 check("async_rst", longint'($signed(out_v)), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    push_lit(cyc + 1, 0);
    push_lit(cyc + 2, 8);
    repeat (4) @(posedge clk);

    // Random streaming
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0: s = int'($urandom);
        1: s = int'($urandom_range(0, 40000)) - 20000;
        2: s = (($urandom_range(0, 1) == 1) ? 1 : -1) *
               (67108864 + int'($urandom_range(0, 20000)) - 10000);
        default: s = (int'($urandom_range(0, 65535)) - 32768) * 4096 +
                     int'($urandom_range(0, 2)) - 1;
      endcase
      drive(s);
    end

    // Half-cycle reset in the middle of a nonzero stream
    drive(123456789);
    #2 rst = 1'b1;
    in_v = '0;
    #5 rst = 1'b0;
    for (int k = 1; k <= 4; k++) push_lit(cyc + k, 0);
    repeat (6) @(posedge clk);

    check("lit_drain", longint'(lit_due.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
